// File: rtl/iir_biquad_seq.sv
// ---------------------------------------------------------------------------
// iir_biquad_seq
//
// Second-order IIR section in direct form I with run-time programmable
// coefficients. A single multiplier is shared over the five taps, so each
// sample takes one accept edge, five multiply-accumulate edges and one
// output edge:
//
//   y[n] = sat((b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2])
//              >>> COEF_FRAC)
//
// a0 is fixed at 1. The shift is arithmetic (floor). The result is clamped
// to the signed OUT_W range. The feedback history keeps the clamped value.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   flush      synchronous abort: drops the in-flight sample, zeroes the
//              history and the accumulator, clears sat_flag. Coefficients
//              and data_out are kept.
//   in_valid   data_in carries a sample
//   in_ready   block is idle and can take a sample
//   data_in    signed input sample x[n]
//   coef_we    coefficient write strobe, honoured only while idle
//   coef_addr  0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 ignored
//   coef_data  signed coefficient, COEF_FRAC fraction bits
//   out_valid  one-cycle pulse, data_out holds the new y[n]
//   data_out   signed saturated output, held until the next result
//   sat_flag   sticky, set when any output was clamped
//
// Handshake: a sample is transferred on a rising edge where in_valid and
// in_ready are both 1. The source keeps data_in stable until then.
// in_ready depends only on internal state, never on in_valid. The output
// side has no backpressure.
// ---------------------------------------------------------------------------
module iir_biquad_seq #(
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 14,
   parameter int OUT_W     = 16,
   parameter int ACC_W     = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic                     coef_we,
   input  logic [2:0]               coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  data_out,
   output logic                     sat_flag
);

   // Multiplier data operand is wide enough for both x and y samples.
   localparam int MW = (DATA_W > OUT_W) ? DATA_W : OUT_W;
   localparam int PW = MW + COEF_W;

   localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << COEF_FRAC;
   localparam logic signed [ACC_W-1:0]  OUT_MAX  =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]  OUT_MIN  = ~OUT_MAX;
   localparam logic signed [OUT_W-1:0]  Y_MAX    = OUT_MAX[OUT_W-1:0];
   localparam logic signed [OUT_W-1:0]  Y_MIN    = OUT_MIN[OUT_W-1:0];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [2:0]               tap_q, tap_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
   logic signed [OUT_W-1:0]  y1_q, y1_d, y2_q, y2_d;
   logic signed [COEF_W-1:0] coef_q [0:4];
   logic signed [COEF_W-1:0] coef_d [0:4];
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]  data_out_q, data_out_d;
   logic                     sat_q, sat_d;

   logic signed [COEF_W-1:0] coef_sel;
   logic signed [MW-1:0]     data_sel;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_shift;
   logic signed [OUT_W-1:0]  y_sat;
   logic                     clip;

   // Tap order b0,b1,b2,a1,a2: the tap index picks the coefficient and the
   // matching history sample for the shared multiplier.
   always_comb begin
      coef_sel = coef_q[4];
      data_sel = MW'(y2_q);
      case (tap_q)
         3'd0: begin coef_sel = coef_q[0]; data_sel = MW'(x0_q); end
         3'd1: begin coef_sel = coef_q[1]; data_sel = MW'(x1_q); end
         3'd2: begin coef_sel = coef_q[2]; data_sel = MW'(x2_q); end
         3'd3: begin coef_sel = coef_q[3]; data_sel = MW'(y1_q); end
         default: ;
      endcase
   end

   assign prod     = PW'(coef_sel) * PW'(data_sel);
   assign prod_ext = ACC_W'(prod);

   // Scale back to the output format and clamp to the signed OUT_W range.
   always_comb begin
      acc_shift = acc_q >>> COEF_FRAC;
      clip      = 1'b0;
      y_sat     = acc_shift[OUT_W-1:0];
      if (acc_shift > OUT_MAX) begin
         y_sat = Y_MAX;
         clip  = 1'b1;
      end else if (acc_shift < OUT_MIN) begin
         y_sat = Y_MIN;
         clip  = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      acc_d       = acc_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      y1_d        = y1_q;
      y2_d        = y2_q;
      coef_d      = coef_q;
      out_valid_d = 1'b0;
      data_out_d  = data_out_q;
      sat_d       = sat_q;

      if (flush) begin
         // Flush beats both the sample handshake and coefficient writes.
         state_d = ST_IDLE;
         tap_d   = 3'd0;
         acc_d   = '0;
         x0_d    = '0;
         x1_d    = '0;
         x2_d    = '0;
         y1_d    = '0;
         y2_d    = '0;
         sat_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // A write on the accept edge lands before the first MAC
               // edge, so this sample already uses the new value.
               if (coef_we) begin
                  case (coef_addr)
                     3'd0: coef_d[0] = coef_data;
                     3'd1: coef_d[1] = coef_data;
                     3'd2: coef_d[2] = coef_data;
                     3'd3: coef_d[3] = coef_data;
                     3'd4: coef_d[4] = coef_data;
                     default: ;
                  endcase
               end
               if (in_valid) begin
                  x0_d    = data_in;
                  acc_d   = '0;
                  tap_d   = 3'd0;
                  state_d = ST_MAC;
               end
            end
            ST_MAC: begin
               // Feedback taps (a1, a2) are subtracted.
               if (tap_q >= 3'd3) acc_d = acc_q - prod_ext;
               else               acc_d = acc_q + prod_ext;
               tap_d = tap_q + 3'd1;
               if (tap_q == 3'd4) state_d = ST_DONE;
            end
            ST_DONE: begin
               data_out_d  = y_sat;
               out_valid_d = 1'b1;
               sat_d       = sat_q | clip;
               x2_d        = x1_q;
               x1_d        = x0_q;
               y2_d        = y1_q;
               y1_d        = y_sat;
               state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tap_q       <= 3'd0;
         acc_q       <= '0;
         x0_q        <= '0;
         x1_q        <= '0;
         x2_q        <= '0;
         y1_q        <= '0;
         y2_q        <= '0;
         coef_q      <= '{COEF_ONE, '0, '0, '0, '0};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         acc_q       <= acc_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         y1_q        <= y1_d;
         y2_q        <= y2_d;
         coef_q      <= coef_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         sat_q       <= sat_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// ---------------------------------------------------------------------------
// tb_iir_biquad_seq
//
// Directed bench for iir_biquad_seq. A behavioural model of the filter
// equation produces the expected output and sat_flag for every accepted
// sample. These go into a queue, together with the accept cycle. A monitor
// pops the queue on each out_valid and checks the value, the sticky flag
// and the six-cycle latency.
// ---------------------------------------------------------------------------
module tb_iir_biquad_seq;

   localparam int DATA_W    = 8;
   localparam int COEF_W    = 16;
   localparam int COEF_FRAC = 14;
   localparam int OUT_W     = 16;
   localparam int ACC_W     = 40;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] data_in;
   logic              coef_we;
   logic [2:0]        coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic              out_valid;
   logic [OUT_W-1:0]  data_out;
   logic              sat_flag;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [OUT_W-1:0] exp_q[$];
   bit               exp_sat_q[$];
   int               lat_q[$];

   // Reference model state
   longint           m_c[5];
   longint           m_x1, m_x2, m_y1, m_y2;
   bit               m_sat;
   logic [OUT_W-1:0] m_last;

   iir_biquad_seq #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC),
      .OUT_W(OUT_W), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .data_out(data_out), .sat_flag(sat_flag)
   );

   // ---------------- clock / cycle counter / watchdog ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic signed [63:0] observed,
                      input logic signed [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void m_reset();
      m_c    = '{16384, 0, 0, 0, 0};
      m_x1   = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
      m_sat  = 1'b0;
      m_last = '0;
   endfunction

   function automatic void m_flush();
      m_x1  = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
      m_sat = 1'b0;
   endfunction

   function automatic logic [OUT_W-1:0] m_step(input longint x);
      longint acc, y;
      acc = m_c[0]*x + m_c[1]*m_x1 + m_c[2]*m_x2 - m_c[3]*m_y1 - m_c[4]*m_y2;
      y   = acc >>> COEF_FRAC;
      if (y > 32767)  begin y = 32767;  m_sat = 1'b1; end
      if (y < -32768) begin y = -32768; m_sat = 1'b1; end
      m_x2 = m_x1; m_x1 = x;
      m_y2 = m_y1; m_y1 = y;
      m_last = y[OUT_W-1:0];
      return y[OUT_W-1:0];
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'sd0);
         end else begin
            logic [OUT_W-1:0] e;
            bit               s;
            int               l;
            e = exp_q.pop_front();
            s = exp_sat_q.pop_front();
            l = lat_q.pop_front();
            chk("data_out", $signed(data_out), $signed(e));
            chk("sat_flag", 64'(sat_flag), 64'(s));
            chk("latency", 64'(cyc - l), 64'sd6);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // wr_mode: 0 no write, 1 write on the accept edge, 2 write during MAC
   task automatic send(input int x, input bit track, input int wr_mode,
                       input int waddr, input int wval);
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_wait", 64'(in_ready), 64'sd1);
      in_valid = 1'b1;
      data_in  = DATA_W'(x);
      if (wr_mode == 1) begin
         coef_we   = 1'b1;
         coef_addr = 3'(waddr);
         coef_data = COEF_W'(wval);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      if (wr_mode == 1 && waddr < 5) m_c[waddr] = wval;
      if (track) begin
         exp_q.push_back(m_step(x));
         exp_sat_q.push_back(m_sat);
         lat_q.push_back(cyc);
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("in_ready_busy", 64'(in_ready), 64'sd0);
            if (wr_mode == 2 && i == 1) begin
               coef_we   = 1'b1;
               coef_addr = 3'(waddr);
               coef_data = COEF_W'(wval);
            end
            if (wr_mode == 2 && i == 2) coef_we = 1'b0;
         end
      end
   endtask

   task automatic write_coef(input int addr, input int val);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 3'(addr);
      coef_data = COEF_W'(val);
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      if (addr < 5) m_c[addr] = val;
   endtask

   task automatic set_coefs(input int b0, input int b1, input int b2,
                            input int a1, input int a2);
      write_coef(0, b0);
      write_coef(1, b1);
      write_coef(2, b2);
      write_coef(3, a1);
      write_coef(4, a2);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'sd0);
      @(negedge clk);
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      m_flush();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      data_in   = '0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      m_reset();

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'sd1);
      chk("rst_out_valid", 64'(out_valid), 64'sd0);
      chk("rst_data_out", $signed(data_out), 64'sd0);
      chk("rst_sat_flag", 64'(sat_flag), 64'sd0);
      rst = 1'b0;

      // Pass-through after reset
      send(100, 1, 0, 0, 0);
      send(-128, 1, 0, 0, 0);
      drain();
      chk("s1_last", $signed(data_out), -64'sd128);

      // FIR taps, including floor of a negative half
      set_coefs(8192, 8192, 0, 0, 0);
      send(64, 1, 0, 0, 0);
      send(0, 1, 0, 0, 0);
      send(0, 1, 0, 0, 0);
      send(-3, 1, 0, 0, 0);
      drain();
      chk("s2_floor", $signed(data_out), -64'sd2);

      do_flush();
      chk("flush_keeps_data_out", $signed(data_out), -64'sd2);

      // Recursion: decaying impulse response
      set_coefs(16384, 0, 0, -8192, 0);
      for (int i = 0; i < 8; i++) send((i == 0) ? 64 : 0, 1, 0, 0, 0);
      drain();
      chk("s3_tail", $signed(data_out), 64'sd0);

      // Write b0 on the same edge as the accept
      send(100, 1, 1, 0, 8192);
      drain();
      chk("same_edge_write", $signed(data_out), 64'sd50);

      // Address 5 is not a coefficient
      write_coef(5, 1234);
      send(40, 1, 0, 0, 0);
      drain();

      // Positive saturation
      do_flush();
      set_coefs(32767, 0, 0, -16384, 0);
      for (int i = 0; i < 140; i++) send(127, 1, 0, 0, 0);
      drain();
      chk("sat_pos_value", $signed(data_out), 64'sd32767);
      chk("sat_pos_flag", 64'(sat_flag), 64'sd1);

      do_flush();
      chk("flush_clears_sat", 64'(sat_flag), 64'sd0);

      // Negative saturation
      for (int i = 0; i < 140; i++) send(-128, 1, 0, 0, 0);
      drain();
      chk("sat_neg_value", $signed(data_out), -64'sd32768);
      chk("sat_neg_flag", 64'(sat_flag), 64'sd1);

      // Coefficient write during MAC is ignored
      set_coefs(16384, 0, 0, -8192, 0);
      send(64, 1, 2, 0, 0);
      send(64, 1, 0, 0, 0);
      drain();

      // Flush at E3 drops the in-flight sample
      send(64, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      m_flush();
      repeat (10) @(negedge clk);
      chk("flush_mid_sat", 64'(sat_flag), 64'sd0);
      chk("flush_mid_ready", 64'(in_ready), 64'sd1);
      chk("flush_mid_data_out", $signed(data_out), $signed(m_last));
      for (int i = 0; i < 8; i++) send((i == 0) ? 64 : 0, 1, 0, 0, 0);
      drain();
      chk("flush_impulse_sat", 64'(sat_flag), 64'sd0);

      // Reset asserted between edges while a sample is in MAC
      send(100, 1, 0, 0, 0);
      drain();
      send(77, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", 64'(out_valid), 64'sd0);
      chk("rst_mid_data_out", $signed(data_out), 64'sd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'sd1);
      chk("rst_mid_sat_flag", 64'(sat_flag), 64'sd0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      send(50, 1, 0, 0, 0);
      drain();
      chk("rst_passthrough", $signed(data_out), 64'sd50);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
